// File: rtl/pipe_stage_buffer.sv
// pipe_stage_buffer: DEPTH-entry in-order valid/ready pipeline stage buffer with flush and bubble output
module pipe_stage_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
    $error("pipe_stage_buffer: DEPTH must be in 1..8");
  end
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic             push, pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH-1) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    in_ready  = count < CW'(DEPTH);
    out_valid = count != '0;
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
    out_data  = out_valid ? mem[rd_ptr] : BUBBLE;
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      count  <= count + CW'(push) - CW'(pop);
      rd_ptr <= pop ? nxt(rd_ptr) : rd_ptr;
      wr_ptr <= push ? nxt(wr_ptr) : wr_ptr;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && !flush && push) mem[wr_ptr] <= in_data;
  end
endmodule
